// File: rtl/pbit_histogram_accumulator.sv
// Histogram of p-bit state vectors, binned on every sample-phase change of clk_delay.
// Optional saturating counters and sticky sat_flag when HIST_SATURATE_EN is defined.
module pbit_histogram_accumulator #(
  parameter int NUM_PBITS = 8,
  parameter int COUNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PBITS-1:0] pbits,
  input  logic [1:0]           clk_delay,
  input  logic                 acc_en,
  input  logic                 clear,
  output logic                 busy,
  input  logic                 rd_en,
  input  logic [NUM_PBITS-1:0] rd_addr,
  output logic                 rd_valid,
  output logic [COUNT_W-1:0]   rd_data,
  output logic [COUNT_W-1:0]   total_samples,
  output logic                 sat_flag
);

  localparam int DEPTH = 1 << NUM_PBITS;

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e               state_q, state_d;
  logic [NUM_PBITS-1:0] clr_addr_q, clr_addr_d;
  logic [1:0]           prev_delay_q;
  logic                 tick_q, tick_d;
  logic                 cap_valid_q, cap_valid_d;
  logic [NUM_PBITS-1:0] cap_addr_q, cap_addr_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [NUM_PBITS-1:0] wr_addr_q, wr_addr_d;
  logic [COUNT_W-1:0]   wr_data_q, wr_data_d;
  logic [COUNT_W-1:0]   total_q, total_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [COUNT_W-1:0]   rd_data_q, rd_data_d;

  logic [COUNT_W-1:0]   bin_old, bin_inc, total_inc;
  logic                 hist_we;
  logic                 mem_we;
  logic [NUM_PBITS-1:0] mem_waddr;
  logic [COUNT_W-1:0]   mem_wdata;

  logic [COUNT_W-1:0]   mem [DEPTH];

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // FSM: next state
  // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (clear) begin
      state_d    = ST_CLEAR;
      clr_addr_d = '0;
    end else if (state_q == ST_CLEAR) begin
      if (&clr_addr_q) begin
        state_d    = ST_RUN;
        clr_addr_d = '0;
      end else begin
        clr_addr_d = clr_addr_q + NUM_PBITS'(1);
      end
    end
  end

  // FSM: outputs; the sweep owns the memory write port while clearing
  always_comb begin
    busy      = (state_q == ST_CLEAR);
    mem_we    = 1'b0;
    mem_waddr = clr_addr_q;
    mem_wdata = '0;
    if (state_q == ST_CLEAR) begin
      mem_we = 1'b1;
    end else if (hist_we) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr_q;
      mem_wdata = wr_data_q;
    end
  end

  // clear flushes every stage so no in-flight sample lands after the sweep starts
  always_comb begin
    tick_d      = (state_q == ST_RUN) && acc_en && (clk_delay != prev_delay_q) && !clear;
    cap_valid_d = tick_q && !clear;
    cap_addr_d  = pbits;
    bin_old     = (wr_valid_q && (wr_addr_q == cap_addr_q)) ? wr_data_q : mem[cap_addr_q];
    wr_valid_d  = cap_valid_q && !clear;
    wr_addr_d   = cap_addr_q;
    wr_data_d   = bin_inc;
  end

  assign hist_we = wr_valid_q && !clear;

  always_comb begin
    total_d = total_q;
    if (clear) begin
      total_d = '0;
    end else if (hist_we) begin
      total_d = total_inc;
    end
  end

`ifdef HIST_SATURATE_EN
  logic wr_ovf_q, wr_ovf_d;
  logic sat_q, sat_d;

  always_comb begin
    bin_inc   = (&bin_old) ? bin_old : bin_old + COUNT_W'(1);
    total_inc = (&total_q) ? total_q : total_q + COUNT_W'(1);
    wr_ovf_d  = &bin_old;
    sat_d     = sat_q;
    if (clear) begin
      sat_d = 1'b0;
    end else if (hist_we && (wr_ovf_q || (&total_q))) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ovf_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      wr_ovf_q <= wr_ovf_d;
      sat_q    <= sat_d;
    end
  end

  assign sat_flag = sat_q;
`else
  always_comb begin
    bin_inc   = bin_old + COUNT_W'(1);
    total_inc = total_q + COUNT_W'(1);
  end

  assign sat_flag = 1'b0;
`endif

  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_en ? mem[rd_addr] : rd_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_delay_q <= 2'b00;
      tick_q       <= 1'b0;
      cap_valid_q  <= 1'b0;
      cap_addr_q   <= '0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      total_q      <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      prev_delay_q <= clk_delay;
      tick_q       <= tick_d;
      cap_valid_q  <= cap_valid_d;
      cap_addr_q   <= cap_addr_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      total_q      <= total_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // NOTE: the bin array has no reset; the clear sweep zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign total_samples = total_q;

endmodule

// File: tb/tb_pbit_histogram_accumulator.sv
// Scoreboard bench for pbit_histogram_accumulator: a per-cycle count model feeds expected reads
// into a queue that a negedge monitor drains. Honours HIST_SATURATE_EN for the expected values.
module tb_pbit_histogram_accumulator;

  localparam int NP    = 8;
  localparam int CW    = 4;
  localparam int DEPTH = 1 << NP;
  localparam int MAXV  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [NP-1:0] pbits;
  logic [1:0]    clk_delay;
  logic          acc_en;
  logic          clear;
  logic          busy;
  logic          rd_en;
  logic [NP-1:0] rd_addr;
  logic          rd_valid;
  logic [CW-1:0] rd_data;
  logic [CW-1:0] total_samples;
  logic          sat_flag;

  always #5 clk = ~clk;

  pbit_histogram_accumulator #(.NUM_PBITS(NP), .COUNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .pbits         (pbits),
    .clk_delay     (clk_delay),
    .acc_en        (acc_en),
    .clear         (clear),
    .busy          (busy),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .total_samples (total_samples),
    .sat_flag      (sat_flag)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: true (unbounded) sample counts, mapped to the visible counter value on demand
  int       cnt [DEPTH];
  int       total_raw;
  int       busy_left;
  bit       pend;
  logic [1:0] last_d;
  int       cyc;

  typedef struct {
    int bin;
    int exp_data;
    int exp_total;
    int issue;
  } rd_exp_t;

  rd_exp_t rq [$];
  rd_exp_t mon_e;

  function automatic int shown(input int n);
`ifdef HIST_SATURATE_EN
    return (n > MAXV) ? MAXV : n;
`else
    return n % (MAXV + 1);
`endif
  endfunction

  function automatic int exp_sat();
`ifdef HIST_SATURATE_EN
    return (total_raw > MAXV) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // One clock with the currently driven inputs; the model follows the sampling rules directly.
  task automatic cycle();
    bit run;
    bit tick;
    run = (busy_left == 0);
    check("busy", busy, run ? 0 : 1);
    if (pend && !clear) begin
      cnt[pbits]++;
      total_raw++;
    end
    tick = (clk_delay != last_d) && acc_en && run;
    if (clear) begin
      foreach (cnt[i]) cnt[i] = 0;
      total_raw = 0;
      pend      = 1'b0;
      busy_left = DEPTH;
    end else begin
      pend = tick;
      if (busy_left > 0) busy_left--;
    end
    last_d = clk_delay;
    @(posedge clk);
    #1;
    cyc++;
    rd_en = 1'b0;
    clear = 1'b0;
  endtask

  task automatic read_bin(input int a);
    rd_en   = 1'b1;
    rd_addr = NP'(a);
    rq.push_back('{a, shown(cnt[a]), shown(total_raw), cyc});
    cycle();
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) read_bin(a);
  endtask

  task automatic settle();
    repeat (4) cycle();
  endtask

  task automatic clear_and_wait();
    clear = 1'b1;
    cycle();
    while (busy_left > 0) cycle();
  endtask

  always @(negedge clk) begin
    if (!reset && rd_valid) begin
      if (rq.size() == 0) begin
        check("rd_valid_unexpected", 1, 0);
      end else begin
        mon_e = rq.pop_front();
        check("rd_latency", cyc, mon_e.issue + 1);
        check($sformatf("bin_%02h", mon_e.bin), rd_data, mon_e.exp_data);
        check("total_samples", total_samples, mon_e.exp_total);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    pbits     = '0;
    clk_delay = 2'd0;
    acc_en    = 1'b0;
    clear     = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    foreach (cnt[i]) cnt[i] = 0;
    total_raw = 0;
    pend      = 1'b0;
    last_d    = 2'd0;
    cyc       = 0;
    busy_left = DEPTH;

    #1;
    check("reset_busy", busy, 1);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_total", total_samples, 0);
    check("reset_sat", sat_flag, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Sweep after reset: busy for exactly DEPTH cycles, then every bin reads zero
    repeat (DEPTH) cycle();
    check("busy_after_sweep", busy, 0);
    read_all();

    // Four spaced samples at 0xA5
    acc_en = 1'b1;
    pbits  = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      clk_delay = clk_delay + 2'd1;
      repeat (3) cycle();
    end
    settle();
    read_all();
    clear_and_wait();

    // Ten back-to-back samples at 0x3C exercise write forwarding
    pbits = 8'h3C;
    repeat (10) begin
      clk_delay = clk_delay + 2'd1;
      cycle();
    end
    settle();
    read_bin(8'h3C);
    read_bin(8'h3B);
    read_bin(8'h3D);
    clear_and_wait();

    // Alternating 0x01/0x02 on six back-to-back samples
    for (int k = 0; k < 7; k++) begin
      if (k < 6) clk_delay = clk_delay + 2'd1;
      pbits = (k % 2 == 1) ? 8'h01 : 8'h02;
      cycle();
    end
    settle();
    for (int a = 0; a < 4; a++) read_bin(a);

    // Randomised phase changes, enables and hot bins
    repeat (300) begin
      acc_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2) != 0) clk_delay = 2'($urandom);
      pbits = ($urandom_range(0, 3) == 0) ? NP'($urandom) : NP'($urandom_range(0, 5));
      cycle();
    end
    acc_en = 1'b1;
    settle();
    for (int a = 0; a < 8; a++) read_bin(a);
    repeat (16) read_bin(int'($urandom_range(0, DEPTH - 1)));
    check("sat_after_random", sat_flag, exp_sat());

    // Twenty samples at 0xFF overflow a 4-bit counter
    clear_and_wait();
    check("sat_cleared", sat_flag, 0);
    pbits = 8'hFF;
    repeat (20) begin
      clk_delay = clk_delay + 2'd1;
      repeat ($urandom_range(1, 2)) cycle();
    end
    settle();
    read_bin(8'hFF);
    read_bin(8'hFE);
    check("sat_after_ff", sat_flag, exp_sat());

    // clear right after a tick cancels the in-flight sample; samples during busy are dropped
    clear_and_wait();
    pbits     = 8'h07;
    clk_delay = clk_delay + 2'd1;
    cycle();
    clear = 1'b1;
    cycle();
    repeat (5) begin
      clk_delay = clk_delay + 2'd1;
      cycle();
    end
    while (busy_left > 0) cycle();
    settle();
    read_all();
    check("sat_after_clear", sat_flag, 0);

    repeat (3) cycle();
    check("rd_queue_drained", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pbit_histogram_accumulator.md
Name: pbit_histogram_accumulator

Overview:
- Downstream consumer of the probabilistic p-bit array: watches the array's 2-bit sample-phase output and, on every phase change, bins the current p-bit state vector into an on-chip histogram.
- Replaces simulation-only occurrence counting with synthesizable counters, so the p-circuit output distribution can be read back from hardware.
- Sits between the p-bit top level (out, clk_delay) and the readout/debug interface.

Parameters:
- NUM_PBITS, 8, width of the p-bit state vector; histogram depth = 2**NUM_PBITS bins.
- COUNT_W, 32, width of each bin counter and of the total-sample counter.

Ports:
- clk  input  1  system clock, same domain as the p-bit array.
- reset  input  1  asynchronous, active-high reset.
- pbits  input  NUM_PBITS  p-bit state vector from the array (out).
- clk_delay  input  2  sample-phase code from the array; any change marks a new sample.
- acc_en  input  1  1 = accumulate samples; 0 = samples ignored.
- clear  input  1  single-cycle request to zero all bins and the total.
- busy  output  1  high while clearing.
- rd_en  input  1  bin read request.
- rd_addr  input  NUM_PBITS  bin index to read.
- rd_valid  output  1  rd_data valid, exactly 1 cycle after rd_en.
- rd_data  output  COUNT_W  bin count.
- total_samples  output  COUNT_W  number of samples binned since the last clear.
- sat_flag  output  1  sticky; present only with the optional feature, tied 0 otherwise.

Behaviour:
- Reset (asynchronous): busy=1, rd_valid=0, rd_data=0, total_samples=0, sat_flag=0, prev_delay=0; FSM enters CLEAR at bin 0.
- FSM states:
  - CLEAR: write 0 to one bin per cycle, from 0 up to 2**NUM_PBITS-1. After the last bin, go to RUN and drop busy on the next cycle. A clear sweep takes 2**NUM_PBITS cycles.
  - RUN: accumulate.
  - RUN -> CLEAR on clear=1. clear=1 while already in CLEAR restarts the sweep at bin 0.
- Sample detect: register clk_delay each cycle into prev_delay. tick = (clk_delay != prev_delay) && acc_en && state==RUN.
- Settle: pbits is captured on the cycle after tick, to give the p-bits half a sample window to settle.
- Pipeline, with capture at cycle C:
  - C+1: read the bin.
  - C+2: write bin+1 and increment total_samples.
  - Throughput is one sample per cycle.
- Hazards: back-to-back samples to the same bin forward the in-flight write value; no increment may be lost.
- Counter width: without saturation, both the bin counters and total_samples wrap modulo 2**COUNT_W.
- Samples during CLEAR, or with acc_en=0, are discarded; the pipeline does not capture them.
- clear arriving while samples are in flight: pending pipeline writes are cancelled; the sweep starts the next cycle.
- Read port:
  - Independent of the pipeline.
  - rd_data = stored bin value, registered, 1-cycle latency.
  - A read of the bin being written in the same cycle returns the pre-write value.
  - rd_en during CLEAR returns the stored value, which may be stale.
- Reset asserted mid-operation: all state is discarded immediately and the full sweep repeats.

Optional Feature:
- Macro: HIST_SATURATE_EN.
- Defined:
  - Bin counters and total_samples saturate at 2**COUNT_W-1 instead of wrapping.
  - sat_flag is set the first time any counter would exceed its maximum; it clears only on reset or clear.
- Undefined:
  - Counters wrap.
  - sat_flag is constant 0.
  - No saturation comparators are synthesized.

Test Plan:
- Reset release, NUM_PBITS=8 -> busy=1 for exactly 256 cycles, then 0; reading all 256 bins returns 0; total_samples=0.
- acc_en=1, pbits held at 8'hA5, clk_delay toggled 0->1->2->3->0 (4 changes, 3 cycles apart) -> bin 0xA5 reads 4, all other bins 0, total_samples=4.
- clk_delay changing every cycle for 10 cycles, pbits fixed at 8'h3C -> bin 0x3C reads 10. Verifies the forwarding path.
- Alternating pbits 8'h01/8'h02 over 6 back-to-back samples -> bins 1 and 2 each read 3; total_samples=6.
- clear pulsed 1 cycle after a sample tick, then 5 more samples at 8'h07 during busy -> all bins 0 after the sweep, total_samples=0; the in-flight sample is not written.
- COUNT_W=4, HIST_SATURATE_EN defined, 20 samples at 8'hFF -> bin 0xFF=15, total_samples=15, sat_flag=1. Same run undefined -> bin 0xFF=4, total_samples=4, sat_flag=0.
